// File: rtl/usb3_pkg.sv
// Shared constants for the FX3 slave-FIFO read path; the RAM cache decodes
// usb_rd_state against these same state codes.
package usb3_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SEL       = 4'd1,
        ST_FLAG_WAIT = 4'd2,
        ST_OE        = 4'd3,
        ST_RD_START  = 4'd4,
        ST_RD_DATA   = 4'd6,
        ST_DONE      = 4'd7
    } rd_state_t;

endpackage

// File: rtl/usb3_slfifo_rd.sv
// FX3 synchronous slave-FIFO read master: pulls BURST-word bursts into the cache domain.
// Latency: word appears on data RD_LAT cycles after its SLRD_n-low cycle; all outputs registered.
// Backpressure: a burst starts only with cache_rdy and FLAGA; once OE is entered it runs to completion.
module usb3_slfifo_rd
    import usb3_pkg::*;
#(
    parameter int         BURST       = 256,
    parameter int         RD_LAT      = 2,
    parameter int         FLAG_SETTLE = 2,
    parameter logic [1:0] THREAD_ADDR = 2'b11
) (
    input  logic              wrclock,
    input  logic              rst_n,
    input  logic              cache_rdy,
    input  logic              USB3_FLAGA,
    input  logic [DATA_W-1:0] USB3_DQ,
    output logic              USB3_SLCS_n,
    output logic              USB3_SLOE_n,
    output logic              USB3_SLRD_n,
    output logic [1:0]        USB3_A,
    output logic [DATA_W-1:0] data,
    output logic [3:0]        usb_rd_state,
    output logic              burst_done
);

    localparam logic [7:0] SETTLE_LD = 8'(FLAG_SETTLE - 1);
    localparam logic [1:0] LAT_LD    = 2'(RD_LAT - 1);
    localparam logic [8:0] WORD_LAST = 9'(BURST - 1);
    localparam logic [8:0] RD_HI_AT  = 9'(BURST - RD_LAT);

    rd_state_t   state_q, state_d;
    logic [7:0]  settle_q, settle_d;
    logic [1:0]  lat_q, lat_d;
    logic [8:0]  word_q, word_d;

    logic        cs_n_d, oe_n_d, rd_n_d, done_d;
    logic [1:0]  a_d;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        lat_d    = lat_q;
        word_d   = word_q;
        case (state_q)
            ST_IDLE: begin
                if (cache_rdy) state_d = ST_SEL;
            end
            ST_SEL: begin
                settle_d = SETTLE_LD;
                state_d  = ST_FLAG_WAIT;
            end
            ST_FLAG_WAIT: begin
                if (settle_q != 8'd0)
                    settle_d = settle_q - 8'd1;
                else if (USB3_FLAGA && cache_rdy)
                    state_d = ST_OE;
                else
                    state_d = ST_IDLE;
            end
            ST_OE: begin
                lat_d   = LAT_LD;
                state_d = ST_RD_START;
            end
            ST_RD_START: begin
                if (lat_q != 2'd0) begin
                    lat_d = lat_q - 2'd1;
                end else begin
                    word_d  = 9'd0;
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (word_q == WORD_LAST)
                    state_d = ST_DONE;
                else
                    word_d = word_q + 9'd1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Strobes are decoded from the next state so they change on the same edge as the state code.
    always_comb begin
        cs_n_d = 1'b1;
        oe_n_d = 1'b1;
        rd_n_d = 1'b1;
        done_d = 1'b0;
        a_d    = 2'b00;
        case (state_d)
            ST_SEL, ST_FLAG_WAIT: begin
                cs_n_d = 1'b0;
                a_d    = THREAD_ADDR;
            end
            ST_OE: begin
                cs_n_d = 1'b0;
                oe_n_d = 1'b0;
                a_d    = THREAD_ADDR;
            end
            ST_RD_START: begin
                cs_n_d = 1'b0;
                oe_n_d = 1'b0;
                rd_n_d = 1'b0;
                a_d    = THREAD_ADDR;
            end
            ST_RD_DATA: begin
                cs_n_d = 1'b0;
                oe_n_d = 1'b0;
                // Stop strobing RD_LAT words early: those words are already in the FX3 pipeline.
                rd_n_d = (word_d >= RD_HI_AT);
                a_d    = THREAD_ADDR;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                cs_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge wrclock) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            settle_q    <= 8'd0;
            lat_q       <= 2'd0;
            word_q      <= 9'd0;
            USB3_SLCS_n <= 1'b1;
            USB3_SLOE_n <= 1'b1;
            USB3_SLRD_n <= 1'b1;
            USB3_A      <= 2'b00;
            burst_done  <= 1'b0;
            data        <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            lat_q       <= lat_d;
            word_q      <= word_d;
            USB3_SLCS_n <= cs_n_d;
            USB3_SLOE_n <= oe_n_d;
            USB3_SLRD_n <= rd_n_d;
            USB3_A      <= a_d;
            burst_done  <= done_d;
            if (state_d == ST_RD_DATA)
                data <= USB3_DQ;
        end
    end

    assign usb_rd_state = state_q;

endmodule

// File: tb/tb_usb3_slfifo_rd.sv
// Bench for usb3_slfifo_rd: FX3 read-latency model feeding a scoreboard, one task per scenario.
module tb_usb3_slfifo_rd;
    import usb3_pkg::*;

    localparam int B1 = 256;
    localparam int L1 = 2;
    localparam int B2 = 4;
    localparam int L2 = 3;
    localparam int FS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, crdy_a, flag_a, cs_a, oe_a, rd_a, done_a;
    logic [31:0] dq_a, data_a;
    logic [1:0]  adr_a;
    logic [3:0]  st_a;
    logic        rst_b, crdy_b, flag_b, cs_b, oe_b, rd_b, done_b;
    logic [31:0] dq_b, data_b;
    logic [1:0]  adr_b;
    logic [3:0]  st_b;

    usb3_slfifo_rd #(.BURST(B1), .RD_LAT(L1), .FLAG_SETTLE(FS), .THREAD_ADDR(2'b11)) dut_a (
        .wrclock(clk), .rst_n(rst_a), .cache_rdy(crdy_a), .USB3_FLAGA(flag_a), .USB3_DQ(dq_a),
        .USB3_SLCS_n(cs_a), .USB3_SLOE_n(oe_a), .USB3_SLRD_n(rd_a), .USB3_A(adr_a),
        .data(data_a), .usb_rd_state(st_a), .burst_done(done_a));

    usb3_slfifo_rd #(.BURST(B2), .RD_LAT(L2), .FLAG_SETTLE(FS), .THREAD_ADDR(2'b11)) dut_b (
        .wrclock(clk), .rst_n(rst_b), .cache_rdy(crdy_b), .USB3_FLAGA(flag_b), .USB3_DQ(dq_b),
        .USB3_SLCS_n(cs_b), .USB3_SLOE_n(oe_b), .USB3_SLRD_n(rd_b), .USB3_A(adr_b),
        .data(data_b), .usb_rd_state(st_b), .burst_done(done_b));

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    logic [3:0]  hist_a = 4'b0, hist_b = 4'b0;
    logic [31:0] word_a = 32'd0, word_b = 32'd0;
    logic [31:0] exp_a[$];
    logic [31:0] exp_b[$];
    int n6_a, nlow_a, ndone_a, noe_a;
    int n6_b, nlow_b, ndone_b;

    task automatic clr_counts();
        n6_a = 0; nlow_a = 0; ndone_a = 0; noe_a = 0;
        n6_b = 0; nlow_b = 0; ndone_b = 0;
    endtask

    task automatic clear_model();
        hist_a = 4'b0;
        hist_b = 4'b0;
        exp_a.delete();
        exp_b.delete();
    endtask

    // One clock: FX3 models drive DQ for this cycle, then the scoreboard checks any valid word.
    // hist[k] holds "SLRD_n was low" for cycle (now-1-k); FX3 drives the word RD_LAT-1 cycles after the strobe.
    task automatic step();
        logic [31:0] e;
        @(posedge clk);
        #1;
        cyc++;
        if (hist_a[L1-2]) begin
            dq_a = word_a; exp_a.push_back(word_a); word_a = word_a + 32'd1;
        end else begin
            dq_a = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
        end
        hist_a = {hist_a[2:0], ~rd_a};
        if (hist_b[L2-2]) begin
            dq_b = word_b; exp_b.push_back(word_b); word_b = word_b + 32'd1;
        end else begin
            dq_b = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
        end
        hist_b = {hist_b[2:0], ~rd_b};
        if (!rd_a) nlow_a++;
        if (!oe_a) noe_a++;
        if (done_a) ndone_a++;
        if (!rd_b) nlow_b++;
        if (done_b) ndone_b++;
        if (st_a == ST_RD_DATA) begin
            n6_a++;
            total_cnt++;
            if (exp_a.size() == 0) $display("FAIL sb_a_word: got %0h with no word expected", data_a);
            else begin
                e = exp_a.pop_front();
                if (data_a !== e) $display("FAIL sb_a_word: got %0h want %0h", data_a, e);
                else pass_cnt++;
            end
        end
        if (st_b == ST_RD_DATA) begin
            n6_b++;
            total_cnt++;
            if (exp_b.size() == 0) $display("FAIL sb_b_word: got %0h with no word expected", data_b);
            else begin
                e = exp_b.pop_front();
                if (data_b !== e) $display("FAIL sb_b_word: got %0h want %0h", data_b, e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0;
        crdy_a = 1'b1; flag_a = 1'b1; crdy_b = 1'b1; flag_b = 1'b1;
        dq_a = 32'h0; dq_b = 32'h0;
        step(); step();
        total_cnt++; if (st_a !== 4'd0) $display("FAIL rst_state_a: got %0d want 0", st_a); else pass_cnt++;
        total_cnt++; if ({cs_a, oe_a, rd_a, done_a} !== 4'b1110)
            $display("FAIL rst_strobes_a: got %b want 1110", {cs_a, oe_a, rd_a, done_a}); else pass_cnt++;
        total_cnt++; if (adr_a !== 2'b00) $display("FAIL rst_addr_a: got %0d want 0", adr_a); else pass_cnt++;
        total_cnt++; if (data_a !== 32'h0) $display("FAIL rst_data_a: got %0h want 0", data_a); else pass_cnt++;
        total_cnt++; if ({st_b, cs_b, oe_b, rd_b, done_b, adr_b} !== {4'd0, 4'b1110, 2'b00})
            $display("FAIL rst_b: got %b want 0000111000", {st_b, cs_b, oe_b, rd_b, done_b, adr_b}); else pass_cnt++;
        crdy_a = 1'b0; crdy_b = 1'b0;
        rst_a = 1'b1; rst_b = 1'b1;
        step();
        total_cnt++; if (st_a !== 4'd0) $display("FAIL rst_release_idle: got %0d want 0", st_a); else pass_cnt++;
        clear_model();
    endtask

    task automatic test_normal_burst();
        int exp_seq[$];
        int bad_seq = 0, bad_strb = 0, bad_done = 0;
        exp_seq = '{1, 2, 2, 3, 4, 4};
        for (int i = 0; i < B1; i++) exp_seq.push_back(6);
        exp_seq.push_back(7);
        exp_seq.push_back(0);
        clr_counts();
        crdy_a = 1'b1; flag_a = 1'b1;
        for (int i = 0; i < exp_seq.size(); i++) begin
            step();
            if (i == 5) crdy_a = 1'b0;
            if (st_a !== 4'(exp_seq[i])) bad_seq++;
            if ((st_a == ST_DONE) !== done_a) bad_done++;
            if (st_a == ST_RD_DATA && {cs_a, oe_a, adr_a} !== 4'b0011) bad_strb++;
        end
        total_cnt++; if (bad_seq != 0) $display("FAIL n1_state_seq: %0d cycles off, want 0", bad_seq); else pass_cnt++;
        total_cnt++; if (bad_done != 0) $display("FAIL n1_done_align: %0d cycles off, want 0", bad_done); else pass_cnt++;
        total_cnt++; if (bad_strb != 0) $display("FAIL n1_cs_oe_addr: %0d cycles off, want 0", bad_strb); else pass_cnt++;
        total_cnt++; if (nlow_a != B1) $display("FAIL n1_slrd_low: got %0d want %0d", nlow_a, B1); else pass_cnt++;
        total_cnt++; if (n6_a != B1) $display("FAIL n1_valid_cnt: got %0d want %0d", n6_a, B1); else pass_cnt++;
        total_cnt++; if (ndone_a != 1) $display("FAIL n1_done_cnt: got %0d want 1", ndone_a); else pass_cnt++;
        step(); step();
        total_cnt++; if (data_a !== 32'd255) $display("FAIL n1_data_hold: got %0h want ff", data_a); else pass_cnt++;
        total_cnt++; if (exp_a.size() != 0) $display("FAIL n1_sb_left: got %0d want 0", exp_a.size()); else pass_cnt++;
    endtask

    task automatic test_flag_low();
        int n_sel = 0;
        clr_counts();
        crdy_a = 1'b1; flag_a = 1'b0;
        // From IDLE with FLAGA low the loop is IDLE,SEL,FW,FW: SEL on cycles 1,5,...,29.
        for (int i = 0; i < 30; i++) begin
            step();
            if (st_a == ST_SEL) n_sel++;
        end
        total_cnt++; if (n_sel != 8) $display("FAIL fl_retries: got %0d want 8", n_sel); else pass_cnt++;
        total_cnt++; if (n6_a != 0) $display("FAIL fl_no_data: got %0d want 0", n6_a); else pass_cnt++;
        total_cnt++; if (nlow_a + noe_a != 0) $display("FAIL fl_no_rd_oe: got %0d want 0", nlow_a + noe_a); else pass_cnt++;
        flag_a = 1'b1;
        for (int i = 0; i < 700 && ndone_a < 1; i++) begin
            step();
            if (st_a == ST_RD_START) crdy_a = 1'b0;
        end
        total_cnt++; if (ndone_a != 1) $display("FAIL fl_retry_done: got %0d want 1", ndone_a); else pass_cnt++;
        total_cnt++; if (n6_a != B1) $display("FAIL fl_retry_words: got %0d want %0d", n6_a, B1); else pass_cnt++;
        step(); step();
        total_cnt++; if (exp_a.size() != 0) $display("FAIL fl_sb_left: got %0d want 0", exp_a.size()); else pass_cnt++;
    endtask

    task automatic test_cache_not_ready();
        int bad = 0;
        clr_counts();
        crdy_a = 1'b0; flag_a = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (st_a != 4'd0 || {cs_a, oe_a, rd_a} != 3'b111) bad++;
        end
        total_cnt++; if (bad != 0) $display("FAIL cr_idle_hold: %0d cycles off, want 0", bad); else pass_cnt++;
        crdy_a = 1'b1;
        step();
        total_cnt++; if ({st_a, cs_a} !== {4'd1, 1'b0}) $display("FAIL cr_sel_start: got %0d/%b want 1/0", st_a, cs_a); else pass_cnt++;
        for (int i = 0; i < 700 && ndone_a < 1; i++) begin
            step();
            if (st_a == ST_RD_START) crdy_a = 1'b0;
        end
        total_cnt++; if (n6_a != B1) $display("FAIL cr_words: got %0d want %0d", n6_a, B1); else pass_cnt++;
        step(); step();
    endtask

    task automatic test_reset_mid_burst();
        int nrd = 0;
        clr_counts();
        crdy_a = 1'b1; flag_a = 1'b1;
        for (int i = 0; i < 500 && nrd < 100; i++) begin
            step();
            if (st_a == ST_RD_DATA) nrd++;
        end
        total_cnt++; if (nrd != 100) $display("FAIL rm_reach_100: got %0d want 100", nrd); else pass_cnt++;
        rst_a = 1'b0;
        step();
        total_cnt++; if (st_a !== 4'd0) $display("FAIL rm_state: got %0d want 0", st_a); else pass_cnt++;
        total_cnt++; if ({cs_a, oe_a, rd_a, done_a, adr_a} !== 6'b111000)
            $display("FAIL rm_strobes: got %b want 111000", {cs_a, oe_a, rd_a, done_a, adr_a}); else pass_cnt++;
        total_cnt++; if (data_a !== 32'h0) $display("FAIL rm_data: got %0h want 0", data_a); else pass_cnt++;
        rst_a = 1'b1;
        clear_model();
        clr_counts();
        for (int i = 0; i < 700 && ndone_a < 1; i++) begin
            step();
            if (st_a == ST_RD_START) crdy_a = 1'b0;
        end
        total_cnt++; if (n6_a != B1) $display("FAIL rm_fresh_words: got %0d want %0d", n6_a, B1); else pass_cnt++;
        total_cnt++; if (nlow_a != B1) $display("FAIL rm_fresh_slrd: got %0d want %0d", nlow_a, B1); else pass_cnt++;
        step(); step();
        total_cnt++; if (exp_a.size() != 0) $display("FAIL rm_sb_left: got %0d want 0", exp_a.size()); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int t_last6 = -1, t_rs2 = -1;
        bit seen_done = 1'b0;
        logic [3:0] prev;
        clr_counts();
        crdy_a = 1'b1; flag_a = 1'b1;
        prev = st_a;
        for (int i = 0; i < 1500 && ndone_a < 2; i++) begin
            step();
            if (st_a == ST_DONE && prev == ST_RD_DATA && !seen_done) begin
                t_last6 = cyc - 1; seen_done = 1'b1;
            end
            if (seen_done && st_a == ST_RD_START && prev != ST_RD_START && t_rs2 < 0) t_rs2 = cyc;
            prev = st_a;
        end
        crdy_a = 1'b0;
        total_cnt++; if (ndone_a != 2) $display("FAIL bb_done_cnt: got %0d want 2", ndone_a); else pass_cnt++;
        total_cnt++; if (n6_a != 2 * B1) $display("FAIL bb_words: got %0d want %0d", n6_a, 2 * B1); else pass_cnt++;
        // Between the last word and the next RD_START sit DONE, IDLE, SEL, FLAG_WAIT x FS and OE.
        total_cnt++; if (t_rs2 - t_last6 != 5 + FS)
            $display("FAIL bb_gap: got %0d want %0d", t_rs2 - t_last6, 5 + FS); else pass_cnt++;
        step(); step();
        total_cnt++; if (exp_a.size() != 0) $display("FAIL bb_sb_left: got %0d want 0", exp_a.size()); else pass_cnt++;
    endtask

    task automatic test_short_burst();
        logic [31:0] last_b = 32'hFFFF_FFFF;
        clr_counts();
        word_b = 32'd0;
        crdy_b = 1'b1; flag_b = 1'b1;
        for (int i = 0; i < 100 && ndone_b < 1; i++) begin
            step();
            if (st_b == ST_RD_START) crdy_b = 1'b0;
            if (st_b == ST_RD_DATA) last_b = data_b;
        end
        total_cnt++; if (ndone_b != 1) $display("FAIL sb4_done: got %0d want 1", ndone_b); else pass_cnt++;
        total_cnt++; if (nlow_b != B2) $display("FAIL sb4_slrd_low: got %0d want %0d", nlow_b, B2); else pass_cnt++;
        total_cnt++; if (n6_b != B2) $display("FAIL sb4_valid_cnt: got %0d want %0d", n6_b, B2); else pass_cnt++;
        total_cnt++; if (last_b !== 32'd3) $display("FAIL sb4_last_word: got %0h want 3", last_b); else pass_cnt++;
        step(); step();
        total_cnt++; if (exp_b.size() != 0) $display("FAIL sb4_sb_left: got %0d want 0", exp_b.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_normal_burst();
        test_flag_low();
        test_cache_not_ready();
        test_reset_mid_burst();
        test_back_to_back();
        test_short_burst();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
